// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, two response channels and the ALU port of the arbiter.
// Latency: none, signal container only.
// Backpressure: valid/ready on both request and response channels.
interface alu_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_x;
    logic [31:0] req0_y;
    logic [3:0]  req0_func;
    logic [4:0]  req0_shamt;
    logic        req0_src;
    logic        req0_ac;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_x;
    logic [31:0] req1_y;
    logic [3:0]  req1_func;
    logic [4:0]  req1_shamt;
    logic        req1_src;
    logic        req1_ac;
    // shared ALU
    logic        alu_op;
    logic        alu_src;
    logic        alu_ac;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_func;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_sign;
    // responses
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags;

    // arbiter side
    modport slave (
        input  req0_valid, req0_x, req0_y, req0_func, req0_shamt, req0_src, req0_ac,
        output req0_ready,
        input  req1_valid, req1_x, req1_y, req1_func, req1_shamt, req1_src, req1_ac,
        output req1_ready,
        output alu_op, alu_src, alu_ac, alu_x, alu_y, alu_func, alu_shamt,
        input  alu_out, alu_carry, alu_zero, alu_ovf, alu_sign,
        output rsp0_valid, rsp1_valid, rsp_out, rsp_flags,
        input  rsp0_ready, rsp1_ready
    );

    // requesters plus ALU side
    modport master (
        output req0_valid, req0_x, req0_y, req0_func, req0_shamt, req0_src, req0_ac,
        input  req0_ready,
        output req1_valid, req1_x, req1_y, req1_func, req1_shamt, req1_src, req1_ac,
        input  req1_ready,
        input  alu_op, alu_src, alu_ac, alu_x, alu_y, alu_func, alu_shamt,
        output alu_out, alu_carry, alu_zero, alu_ovf, alu_sign,
        input  rsp0_valid, rsp1_valid, rsp_out, rsp_flags,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; latches operands, drives the ALU, returns result+flags.
// Latency: accept edge -> EXEC_CYCLES cycles of alu_op -> response valid the following cycle.
// Backpressure: response held stable until rspN_ready; no request is accepted until the response is consumed.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_MAX = 4'b1001;

    state_t      state;
    state_t      state_nxt;

    logic        rr_ptr;
    logic        owner;
    logic [3:0]  cnt;

    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [3:0]  func_q;
    logic [4:0]  shamt_q;
    logic        src_q;
    logic        ac_q;

    logic [31:0] res_q;
    logic [3:0]  flags_q;

    logic        req_any;
    logic        win;
    logic        accept;
    logic        capture;
    logic        is_add;
    logic        is_undef;
    logic [3:0]  flags_cap;

    // Pick a winner among the valid requesters; rr_ptr breaks ties.
    always_comb begin
        req_any = 1'b0;
        win     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            req_any = 1'b1;
            win     = rr_ptr;
        end else if (bus.req1_valid) begin
            req_any = 1'b1;
            win     = 1'b1;
        end else if (bus.req0_valid) begin
            req_any = 1'b1;
            win     = 1'b0;
        end
    end

    // Only add forms produce meaningful carry/overflow; undefined register-form codes report no flags.
    always_comb begin
        is_add   = (!src_q && (func_q == FUNC_ADD)) || (src_q && !ac_q);
        is_undef = !src_q && (func_q > FUNC_MAX);
        if (is_undef) begin
            flags_cap = 4'b0000;
        end else begin
            flags_cap = {bus.alu_carry & is_add, bus.alu_zero, bus.alu_ovf & is_add, bus.alu_sign};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and all handshake/ALU outputs; ALU inputs are zero outside EXEC.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        capture        = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_op     = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_ac     = 1'b0;
        bus.alu_x      = 32'd0;
        bus.alu_y      = 32'd0;
        bus.alu_func   = 4'd0;
        bus.alu_shamt  = 5'd0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp_out    = 32'd0;
        bus.rsp_flags  = 4'd0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    accept         = 1'b1;
                    bus.req0_ready = !win;
                    bus.req1_ready = win;
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                bus.alu_op    = 1'b1;
                bus.alu_src   = src_q;
                bus.alu_ac    = ac_q;
                bus.alu_x     = x_q;
                bus.alu_y     = y_q;
                bus.alu_func  = func_q;
                bus.alu_shamt = shamt_q;
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp0_valid = !owner;
                bus.rsp1_valid = owner;
                bus.rsp_out    = res_q;
                bus.rsp_flags  = flags_q;
                if ((!owner && bus.rsp0_ready) || (owner && bus.rsp1_ready)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's operands and flip priority to the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            owner   <= 1'b0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            func_q  <= 4'd0;
            shamt_q <= 5'd0;
            src_q   <= 1'b0;
            ac_q    <= 1'b0;
        end else if (accept) begin
            rr_ptr  <= ~win;
            owner   <= win;
            x_q     <= win ? bus.req1_x     : bus.req0_x;
            y_q     <= win ? bus.req1_y     : bus.req0_y;
            func_q  <= win ? bus.req1_func  : bus.req0_func;
            shamt_q <= win ? bus.req1_shamt : bus.req0_shamt;
            src_q   <= win ? bus.req1_src   : bus.req0_src;
            ac_q    <= win ? bus.req1_ac    : bus.req0_ac;
        end
    end

    // Settle counter: loaded on accept, counts down through EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if ((state == EXEC) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture result and masked flags on the last EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= 32'd0;
            flags_q <= 4'd0;
        end else if (capture) begin
            res_q   <= bus.alu_out;
            flags_q <= flags_cap;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (EXEC_CYCLES=1 and 3) each driving a behavioural ALU.
// Latency: n/a.
// Backpressure: response ready is driven per scenario.
module tb_alu_arbiter;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors;
    int   checks;

    alu_arbiter_if ia();
    alu_arbiter_if ib();

    alu_arbiter #(.EXEC_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    alu_arbiter #(.EXEC_CYCLES(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {out, carry, zero, ovf, sign}; carry/ovf always come from x+y.
    function automatic logic [35:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [3:0] f, input logic [4:0] sh,
                                              input logic src, input logic ac);
        logic [32:0] sum;
        logic [31:0] r;
        sum = {1'b0, x} + {1'b0, y};
        if (src) begin
            r = ac ? (~y + 32'd1) : sum[31:0];
        end else begin
            case (f)
                4'd0: r = sum[31:0];
                4'd1: r = ~y + 32'd1;
                4'd2: r = x & y;
                4'd3: r = x ^ y;
                4'd4: r = x << sh;
                4'd5: r = x >> sh;
                4'd6: r = x << y[4:0];
                4'd7: r = x >> y[4:0];
                4'd8: r = $signed(x) >>> sh;
                4'd9: r = $signed(x) >>> y[4:0];
                default: r = 32'h8000_0000;
            endcase
        end
        return {r, sum[32], (r == 32'd0), (x[31] == y[31]) && (sum[31] != x[31]), r[31]};
    endfunction

    assign {ia.alu_out, ia.alu_carry, ia.alu_zero, ia.alu_ovf, ia.alu_sign} =
        alu_model(ia.alu_x, ia.alu_y, ia.alu_func, ia.alu_shamt, ia.alu_src, ia.alu_ac);
    assign {ib.alu_out, ib.alu_carry, ib.alu_zero, ib.alu_ovf, ib.alu_sign} =
        alu_model(ib.alu_x, ib.alu_y, ib.alu_func, ib.alu_shamt, ib.alu_src, ib.alu_ac);

    task automatic clear_inputs();
        ia.req0_valid = 0; ia.req0_x = 0; ia.req0_y = 0; ia.req0_func = 0; ia.req0_shamt = 0; ia.req0_src = 0; ia.req0_ac = 0;
        ia.req1_valid = 0; ia.req1_x = 0; ia.req1_y = 0; ia.req1_func = 0; ia.req1_shamt = 0; ia.req1_src = 0; ia.req1_ac = 0;
        ia.rsp0_ready = 0; ia.rsp1_ready = 0;
        ib.req0_valid = 0; ib.req0_x = 0; ib.req0_y = 0; ib.req0_func = 0; ib.req0_shamt = 0; ib.req0_src = 0; ib.req0_ac = 0;
        ib.req1_valid = 0; ib.req1_x = 0; ib.req1_y = 0; ib.req1_func = 0; ib.req1_shamt = 0; ib.req1_src = 0; ib.req1_ac = 0;
        ib.rsp0_ready = 0; ib.rsp1_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_a = 1; rst_b = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({ia.alu_op, ia.rsp0_valid, ia.rsp1_valid, ia.req0_ready, ia.req1_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl_a: got %b expected 00000", {ia.alu_op, ia.rsp0_valid, ia.rsp1_valid, ia.req0_ready, ia.req1_ready}); end
        checks++; if ({ib.alu_op, ib.rsp0_valid, ib.rsp1_valid, ib.req0_ready, ib.req1_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl_b: got %b expected 00000", {ib.alu_op, ib.rsp0_valid, ib.rsp1_valid, ib.req0_ready, ib.req1_ready}); end
        checks++; if ({ia.alu_x, ia.alu_y, ia.rsp_out} !== 96'd0) begin
            errors++; $display("FAIL reset_data_a: got %h %h %h expected zeros", ia.alu_x, ia.alu_y, ia.rsp_out); end
        checks++; if ({ia.rsp_flags, ib.rsp_flags, ia.alu_func, ia.alu_shamt} !== 17'd0) begin
            errors++; $display("FAIL reset_flags: got %h %h expected 0", ia.rsp_flags, ib.rsp_flags); end
        @(negedge clk);
        rst_a = 0; rst_b = 0;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        ia.req0_valid = 1; ia.req0_x = 32'h7FFF_FFFF; ia.req0_y = 32'd1; ia.req0_func = 4'd0; ia.req0_src = 0; ia.req0_ac = 0;
        #1;
        checks++; if ({ia.req0_ready, ia.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL add_ready: got %b expected 10", {ia.req0_ready, ia.req1_ready}); end
        @(negedge clk);
        ia.req0_valid = 0;
        #1;
        checks++; if ({ia.alu_op, ia.rsp0_valid} !== 2'b10) begin
            errors++; $display("FAIL add_exec: got op/rsp %b expected 10", {ia.alu_op, ia.rsp0_valid}); end
        checks++; if ({ia.alu_x, ia.alu_y} !== {32'h7FFF_FFFF, 32'd1}) begin
            errors++; $display("FAIL add_operands: got %h %h expected 7fffffff 00000001", ia.alu_x, ia.alu_y); end
        @(negedge clk);
        #1;
        checks++; if ({ia.alu_op, ia.rsp0_valid, ia.rsp1_valid} !== 3'b010) begin
            errors++; $display("FAIL add_rsp_valid: got op/rsp0/rsp1 %b expected 010", {ia.alu_op, ia.rsp0_valid, ia.rsp1_valid}); end
        checks++; if (ia.rsp_out !== 32'h8000_0000) begin
            errors++; $display("FAIL add_out: got %h expected 80000000", ia.rsp_out); end
        checks++; if (ia.rsp_flags !== 4'b0011) begin
            errors++; $display("FAIL add_flags: got %b expected 0011", ia.rsp_flags); end
        ia.rsp0_ready = 1;
        @(negedge clk);
        #1;
        checks++; if (ia.rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL add_release: got %b expected 0", ia.rsp0_valid); end
        ia.rsp0_ready = 0;
    endtask

    task automatic test_undef_func();
        @(negedge clk);
        ia.req0_valid = 1; ia.req0_x = 32'hFFFF_FFFF; ia.req0_y = 32'd1; ia.req0_func = 4'b1010; ia.req0_src = 0;
        @(negedge clk);
        ia.req0_valid = 0;
        @(negedge clk);
        #1;
        checks++; if ({ia.rsp0_valid, ia.rsp_out, ia.rsp_flags} !== {1'b1, 32'h8000_0000, 4'b0000}) begin
            errors++; $display("FAIL undef_capture: got v=%b out=%h flags=%b expected 1 80000000 0000", ia.rsp0_valid, ia.rsp_out, ia.rsp_flags); end
        ia.rsp0_ready = 1;
        @(negedge clk);
        ia.rsp0_ready = 0;
    endtask

    task automatic test_contention();
        int order[8];
        int at[8];
        int n = 0;
        int g0 = 0;
        int g1 = 0;
        int rsps = 0;
        int last_owner = 0;
        bit drop0 = 0;
        bit drop1 = 0;
        @(negedge clk); rst_a = 1;
        @(negedge clk); rst_a = 0;
        ia.req0_x = 32'd10; ia.req0_y = 32'd1; ia.req0_func = 0; ia.req0_src = 0;
        ia.req1_x = 32'd20; ia.req1_y = 32'd2; ia.req1_func = 0; ia.req1_src = 0;
        ia.req0_valid = 1; ia.req1_valid = 1;
        ia.rsp0_ready = 1; ia.rsp1_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (drop0) ia.req0_valid = 0;
            if (drop1) ia.req1_valid = 0;
            #1;
            checks++; if (ia.req0_ready && ia.req1_ready) begin
                errors++; $display("FAIL cont_one_ready: cycle %0d both readies high, expected at most one", cyc); end
            if (ia.rsp0_valid || ia.rsp1_valid) begin
                rsps++;
                checks++; if ({ia.rsp1_valid, ia.rsp0_valid} !== (last_owner == 1 ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL cont_route: got rsp1/rsp0 %b owner %0d", {ia.rsp1_valid, ia.rsp0_valid}, last_owner); end
                checks++; if (ia.rsp_out !== (last_owner == 1 ? 32'd22 : 32'd11)) begin
                    errors++; $display("FAIL cont_data: got %0d for owner %0d", ia.rsp_out, last_owner); end
            end
            if (ia.req0_valid && ia.req0_ready) begin
                if (n < 8) begin order[n] = 0; at[n] = cyc; end
                n++; g0++; last_owner = 0;
                if (g0 == 4) drop0 = 1;
            end
            if (ia.req1_valid && ia.req1_ready) begin
                if (n < 8) begin order[n] = 1; at[n] = cyc; end
                n++; g1++; last_owner = 1;
                if (g1 == 4) drop1 = 1;
            end
        end
        checks++; if (n != 8 || rsps != 8) begin
            errors++; $display("FAIL cont_count: got %0d grants %0d responses expected 8 8", n, rsps); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++; if (order[i] != (i % 2)) begin
                errors++; $display("FAIL cont_order: grant %0d went to %0d expected %0d", i, order[i], i % 2); end
        end
        for (int i = 1; i < 8 && i < n; i++) begin
            checks++; if (at[i] - at[i-1] != 3) begin
                errors++; $display("FAIL cont_spacing: grant %0d spacing %0d expected 3", i, at[i] - at[i-1]); end
        end
        clear_inputs();
    endtask

    task automatic test_flag_hold();
        int w = 0;
        @(negedge clk);
        ia.req1_valid = 1; ia.req1_x = 32'hFFFF_FFFF; ia.req1_y = 32'hFFFF_FFFF; ia.req1_func = 4'd3; ia.req1_src = 0;
        #1;
        checks++; if (ia.req1_ready !== 1'b1) begin
            errors++; $display("FAIL xor_ready: got %b expected 1", ia.req1_ready); end
        @(negedge clk);
        ia.req1_valid = 0;
        #1;
        while (ia.rsp1_valid !== 1'b1 && w < 10) begin
            @(negedge clk); #1; w++;
        end
        checks++; if (ia.rsp1_valid !== 1'b1) begin
            errors++; $display("FAIL xor_timeout: rsp1_valid %b after %0d cycles expected 1", ia.rsp1_valid, w); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({ia.rsp1_valid, ia.rsp0_valid, ia.rsp_out, ia.rsp_flags} !== {2'b10, 32'd0, 4'b0100}) begin
                errors++; $display("FAIL xor_hold: cycle %0d got v1=%b v0=%b out=%h flags=%b expected 1 0 0 0100", i, ia.rsp1_valid, ia.rsp0_valid, ia.rsp_out, ia.rsp_flags); end
            @(negedge clk); #1;
        end
        ia.rsp1_ready = 1;
        checks++; if (ia.rsp1_valid !== 1'b1) begin
            errors++; $display("FAIL xor_pre_release: got %b expected 1", ia.rsp1_valid); end
        @(negedge clk);
        #1;
        checks++; if (ia.rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL xor_release: got %b expected 0", ia.rsp1_valid); end
        ia.rsp1_ready = 0;
    endtask

    task automatic test_compi();
        int ops = 0;
        int first_rsp = -1;
        logic [31:0] out_seen = 0;
        logic [3:0]  flags_seen = 0;
        @(negedge clk);
        ib.req0_valid = 1; ib.req0_x = 32'hFFFF_FFFF; ib.req0_y = 32'd5; ib.req0_src = 1; ib.req0_ac = 1; ib.req0_func = 4'd7;
        #1;
        checks++; if (ib.req0_ready !== 1'b1) begin
            errors++; $display("FAIL compi_ready: got %b expected 1", ib.req0_ready); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) ib.req0_valid = 0;
            #1;
            if (k == 1) begin
                checks++; if ({ib.alu_src, ib.alu_ac, ib.alu_y} !== {2'b11, 32'd5}) begin
                    errors++; $display("FAIL compi_ctl: got src=%b ac=%b y=%h expected 1 1 5", ib.alu_src, ib.alu_ac, ib.alu_y); end
            end
            if (ib.alu_op === 1'b1) ops++;
            if (ib.rsp0_valid === 1'b1 && first_rsp < 0) begin
                first_rsp = k; out_seen = ib.rsp_out; flags_seen = ib.rsp_flags;
            end
        end
        checks++; if (ops != 3) begin
            errors++; $display("FAIL compi_op_cycles: got %0d expected 3", ops); end
        checks++; if (first_rsp != 4) begin
            errors++; $display("FAIL compi_latency: rsp at cycle %0d expected 4", first_rsp); end
        checks++; if ({out_seen, flags_seen} !== {32'hFFFF_FFFB, 4'b0001}) begin
            errors++; $display("FAIL compi_result: got %h %b expected fffffffb 0001", out_seen, flags_seen); end
        ib.rsp0_ready = 1;
        @(negedge clk);
        #1;
        checks++; if (ib.rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL compi_release: got %b expected 0", ib.rsp0_valid); end
        ib.rsp0_ready = 0;
    endtask

    task automatic test_reset_mid();
        int w = 0;
        @(negedge clk);
        ib.req0_valid = 1; ib.req0_x = 32'd1; ib.req0_y = 32'd2; ib.req0_func = 0; ib.req0_src = 0; ib.req0_ac = 0;
        #1;
        checks++; if (ib.req0_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready: got %b expected 1", ib.req0_ready); end
        @(negedge clk);
        ib.req0_valid = 0;
        #1;
        checks++; if (ib.alu_op !== 1'b1) begin
            errors++; $display("FAIL rmid_exec: got %b expected 1", ib.alu_op); end
        rst_b = 1;
        @(negedge clk);
        rst_b = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({ib.rsp0_valid, ib.rsp1_valid, ib.alu_op} !== 3'b000) begin
                errors++; $display("FAIL rmid_quiet: cycle %0d got rsp0/rsp1/op %b expected 000", i, {ib.rsp0_valid, ib.rsp1_valid, ib.alu_op}); end
            @(negedge clk);
        end
        ib.req1_valid = 1; ib.req1_x = 32'd3; ib.req1_y = 32'd4; ib.req1_func = 0; ib.req1_src = 0;
        ib.req0_valid = 1;
        #1;
        checks++; if ({ib.req0_ready, ib.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rmid_first_grant: got %b expected 10", {ib.req0_ready, ib.req1_ready}); end
        @(negedge clk);
        ib.req0_valid = 0; ib.req1_valid = 0;
        #1;
        while (ib.rsp0_valid !== 1'b1 && w < 10) begin
            @(negedge clk); #1; w++;
        end
        checks++; if ({ib.rsp0_valid, ib.rsp_out} !== {1'b1, 32'd3}) begin
            errors++; $display("FAIL rmid_result: got v=%b out=%h expected 1 00000003", ib.rsp0_valid, ib.rsp_out); end
        ib.rsp0_ready = 1;
        @(negedge clk);
        ib.rsp0_ready = 0;
    endtask

    task automatic test_withdrawn();
        @(negedge clk);
        ia.req0_valid = 1; ia.req0_x = 32'd2; ia.req0_y = 32'd3; ia.req0_func = 0; ia.req0_src = 0;
        #1;
        checks++; if (ia.req0_ready !== 1'b1) begin
            errors++; $display("FAIL wd_ready0: got %b expected 1", ia.req0_ready); end
        @(negedge clk);
        ia.req0_valid = 0;
        @(negedge clk);
        #1;
        checks++; if ({ia.rsp0_valid, ia.rsp_out} !== {1'b1, 32'd5}) begin
            errors++; $display("FAIL wd_resp: got v=%b out=%h expected 1 00000005", ia.rsp0_valid, ia.rsp_out); end
        ia.req1_valid = 1; ia.req1_x = 32'd9; ia.req1_y = 32'd9; ia.req1_func = 0; ia.req1_src = 0;
        #1;
        checks++; if (ia.req1_ready !== 1'b0) begin
            errors++; $display("FAIL wd_ready_in_resp: got %b expected 0", ia.req1_ready); end
        @(negedge clk);
        ia.req1_valid = 0;
        ia.rsp0_ready = 1;
        #1;
        checks++; if (ia.rsp0_valid !== 1'b1) begin
            errors++; $display("FAIL wd_resp_hold: got %b expected 1", ia.rsp0_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ia.rsp0_ready = 0;
            #1;
            checks++; if ({ia.alu_op, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid} !== 4'b0000) begin
                errors++; $display("FAIL wd_idle: cycle %0d got op/rdy1/rsp0/rsp1 %b expected 0000", i, {ia.alu_op, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid}); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_a  = 1;
        rst_b  = 1;
        clear_inputs();
        test_reset();
        test_single_add();
        test_undef_func();
        test_contention();
        test_flag_hold();
        test_compi();
        test_reset_mid();
        test_withdrawn();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single KGPRISC ALU between two requesters, for example the main execute path and a secondary address/compare unit.
- Requests arrive on valid/ready handshakes and are granted round-robin.
- The block latches the granted operands and drives the ALU control/operand inputs for a configurable number of settle cycles.
- It then captures result and flags and returns them to the winning requester over a valid/ready response channel.

Parameters:
- EXEC_CYCLES, 1, cycles the ALU inputs are held with alu_op=1 before capture (legal 1..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N=0,1) request pending; operands stable while high.
- reqN_ready  out  1  (N=0,1) request accepted this cycle.
- reqN_x, reqN_y  in  32 each  (N=0,1) operands (signed).
- reqN_func  in  4  (N=0,1) ALU function code (0000 add … 1001 shrav).
- reqN_shamt  in  5  (N=0,1) shift amount.
- reqN_src  in  1  (N=0,1) 0 = register form (func), 1 = immediate form (ac).
- reqN_ac  in  1  (N=0,1) immediate op: 0 addi, 1 compi.
- alu_op, alu_src, alu_ac  out  1 each  ALU control.
- alu_x, alu_y  out  32 each  ALU operands.
- alu_func  out  4  ALU function.
- alu_shamt  out  5  ALU shift amount.
- alu_out  in  32  ALU result.
- alu_carry, alu_zero, alu_ovf, alu_sign  in  1 each  ALU flags.
- rspN_valid  out  1  (N=0,1) response for requester N is available.
- rspN_ready  in  1  (N=0,1) requester N consumes the response.
- rsp_out  out  32  captured result (shared by both responses).
- rsp_flags  out  4  {carry, zero, overflow, sign}.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset: state=IDLE, rr_ptr=0 (req0 favoured), all outputs 0, operand/result registers 0.
- Grant logic (IDLE only, combinational):
  - Only one valid: that requester wins.
  - Both valid: rr_ptr selects the winner.
  - reqN_ready = (state==IDLE) && winner==N. At most one ready per cycle; ready is 0 in EXEC and RESP.
- Accept: on the edge where valid&ready, latch x, y, func, shamt, src, ac and owner id. Set rr_ptr = ~owner. Go to EXEC and load exec counter = EXEC_CYCLES-1.
- EXEC:
  - alu_op=1; alu_* driven from the latched registers.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture alu_out and flags at the clock edge, go to RESP.
- alu_op=0 and alu_x/alu_y/alu_func/alu_shamt/alu_src/alu_ac = 0 in every state except EXEC.
- Flag masking at capture:
  - carry and overflow are forced to 0 unless the op is add: (src==0 && func==0000) or (src==1 && ac==0).
  - zero and sign are taken from the ALU for all ops.
  - Undefined func codes (1010–1111) capture alu_out as-is with flags forced to 0000.
- RESP:
  - rsp<owner>_valid=1; rsp_out/rsp_flags hold the captured values and stay stable until consumed.
  - The other rsp valid is 0.
  - When rsp<owner>_ready=1: go to IDLE next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Timing: handshake at the edge ending cycle n → EXEC in cycles n+1..n+EXEC_CYCLES → rspN_valid high from cycle n+EXEC_CYCLES+1. Minimum request-to-request spacing is EXEC_CYCLES+2 cycles.
- Requester protocol:
  - A requester must hold valid and operands until ready.
  - Dropping valid before ready is legal; the request is not accepted and not remembered.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1…; a requester is never passed over twice in a row.
- Reset mid-operation (EXEC or RESP): next state IDLE, pending response discarded (rspN_valid=0), rr_ptr=0. No partial result is ever presented.
- Overflow/width: the 32-bit result is passed through unmodified; no saturation.

Test Plan:
- Single add, EXEC_CYCLES=1:
  - Stimulus: req0 x=0x7FFFFFFF, y=1, func=0000, src=0.
  - Response: req0_ready in the accept cycle; alu_op=1 exactly 1 cycle; rsp0_valid 2 cycles after accept; rsp_out=0x80000000; rsp_flags=0b0011 (ovf=1, sign=1, carry=0, zero=0).
- Contention:
  - Stimulus: req0 and req1 both valid continuously with 4 requests each; rsp ready tied high.
  - Response: grant order 0,1,0,1,0,1,0,1; each response routed to the correct rspN_valid; spacing between accepts = 3 cycles.
- Flag masking and hold:
  - Stimulus: req1 xor x=0xFFFFFFFF, y=0xFFFFFFFF; rsp1_ready held low 5 cycles.
  - Response: rsp_out=0; flags=0b0100; rsp1_valid and data stable all 5 cycles; released one cycle after ready.
- Immediate compi, EXEC_CYCLES=3:
  - Stimulus: req0 src=1, ac=1, y=5.
  - Response: alu_op high exactly 3 cycles; rsp_out=0xFFFFFFFB; flags=0b0001.
- Reset mid-EXEC:
  - Stimulus: assert rst during EXEC (EXEC_CYCLES=3); release it, then present req0 and req1 together.
  - Response: no rsp valid asserted after rst; req0 wins the first grant (rr_ptr=0).
- Withdrawn request:
  - Stimulus: req1 valid for 1 cycle while the arbiter is in RESP for req0, then req1 deasserted.
  - Response: req1_ready never asserts; no EXEC for it; the arbiter returns to IDLE and stays there.
